// File: rtl/puf_response_ctrl_if.sv
// ---------------------------------------------------------------------------
// puf_response_ctrl_if
// Bundles every non-clock/reset signal of puf_response_ctrl.
//   start      host request pulse, sampled only while the controller is idle
//   challenge  base oscillator index captured with an accepted start
//   count_a/b  frozen edge-counter values from PUF banks A and B
//   ro_sel     oscillator select driven to both bank muxes
//   ro_en      oscillator enable (measurement window)
//   cnt_clr    edge-counter clear
//   busy       controller is in a run
//   done       one-cycle pulse when response/tie_mask update
//   response   last completed response word (bit i <- challenge i)
//   tie_mask   bit i set when the two counts were equal for bit i
// Modports: master = host/bank side, slave = controller side.
// ---------------------------------------------------------------------------
interface puf_response_ctrl_if #(
   parameter int NBITS = 8
);
   logic             start;
   logic [4:0]       challenge;
   logic [7:0]       count_a;
   logic [7:0]       count_b;
   logic [4:0]       ro_sel;
   logic             ro_en;
   logic             cnt_clr;
   logic             busy;
   logic             done;
   logic [NBITS-1:0] response;
   logic [NBITS-1:0] tie_mask;

   modport master (
      output start, challenge, count_a, count_b,
      input  ro_sel, ro_en, cnt_clr, busy, done, response, tie_mask
   );

   modport slave (
      input  start, challenge, count_a, count_b,
      output ro_sel, ro_en, cnt_clr, busy, done, response, tie_mask
   );
endinterface

// File: rtl/puf_response_ctrl.sv
// ---------------------------------------------------------------------------
// puf_response_ctrl
// Sequences two ring-oscillator PUF banks: per response bit it selects an
// oscillator pair, clears the edge counters, enables the oscillators for
// WINDOW_CYCLES, waits SETTLE_CYCLES for the counts to freeze, then compares
// the counts and records one response bit and one tie bit. One start pulse
// runs NBITS challenges (base, base+1, ... mod 32) and ends with a done pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active-high (legacy name kept for the codebase)
//   bus    puf_response_ctrl_if.slave (handshake, bank control, results)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module puf_response_ctrl #(
   parameter int WINDOW_CYCLES = 64,
   parameter int SETTLE_CYCLES = 4,
   parameter int NBITS         = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   puf_response_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_SETTLE,
      S_COMPARE,
      S_DONE
   } state_t;

   localparam logic [15:0] WIN_LOAD = 16'(WINDOW_CYCLES - 1);
   localparam logic [15:0] SET_LOAD = 16'(SETTLE_CYCLES - 1);
   localparam logic [4:0]  LAST_IDX = 5'(NBITS - 1);

   state_t           state_q, state_d;
   logic [15:0]      tmr_q;
   logic [4:0]       base_q;
   logic [4:0]       idx_q;
   logic [4:0]       ro_sel_q;
   logic [NBITS-1:0] work_resp_q, work_tie_q;
   logic [NBITS-1:0] work_resp_nxt, work_tie_nxt;
   logic [NBITS-1:0] response_q, tie_q;
   logic             ro_en_q, cnt_clr_q, busy_q, done_q;
   logic             ro_en_d, cnt_clr_d, busy_d, done_d;
   logic             a_gt_b, a_eq_b, last_bit;

   assign a_gt_b   = (bus.count_a > bus.count_b);
   assign a_eq_b   = (bus.count_a == bus.count_b);
   assign last_bit = (idx_q == LAST_IDX);

   // Working registers are cleared at start, so OR-ing in the new bit at
   // position idx is equivalent to writing that bit.
   assign work_resp_nxt = work_resp_q | (NBITS'(a_gt_b) << idx_q);
   assign work_tie_nxt  = work_tie_q  | (NBITS'(a_eq_b) << idx_q);

   // ---- FSM state register ----
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---- FSM next-state logic ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.start) state_d = S_CLEAR;
         S_CLEAR:   state_d = S_RUN;
         S_RUN:     if (tmr_q == 16'd0) state_d = S_SETTLE;
         S_SETTLE:  if (tmr_q == 16'd0) state_d = S_COMPARE;
         S_COMPARE: state_d = last_bit ? S_DONE : S_CLEAR;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // ---- FSM output logic ----
   // Decoded from the next state and registered below, so each output is
   // aligned with the state it belongs to while still coming from a flop.
   always_comb begin
      ro_en_d   = (state_d == S_RUN);
      cnt_clr_d = (state_d == S_CLEAR);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ro_en_q   <= 1'b0;
         cnt_clr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         ro_en_q   <= ro_en_d;
         cnt_clr_q <= cnt_clr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // ---- window / settle down-counter ----
   // Loaded with N-1 on entry so the phase lasts exactly N cycles.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tmr_q <= 16'd0;
      end else begin
         case (state_q)
            S_CLEAR:  tmr_q <= WIN_LOAD;
            S_RUN:    tmr_q <= (tmr_q == 16'd0) ? SET_LOAD : tmr_q - 16'd1;
            S_SETTLE: if (tmr_q != 16'd0) tmr_q <= tmr_q - 16'd1;
            default:  tmr_q <= tmr_q;
         endcase
      end
   end

   // ---- challenge sequencing and response capture ----
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         base_q      <= 5'd0;
         idx_q       <= 5'd0;
         ro_sel_q    <= 5'd0;
         work_resp_q <= '0;
         work_tie_q  <= '0;
         response_q  <= '0;
         tie_q       <= '0;
      end else begin
         if (state_q == S_IDLE && bus.start) begin
            base_q      <= bus.challenge;
            idx_q       <= 5'd0;
            ro_sel_q    <= bus.challenge;
            work_resp_q <= '0;
            work_tie_q  <= '0;
         end
         if (state_q == S_COMPARE) begin
            work_resp_q <= work_resp_nxt;
            work_tie_q  <= work_tie_nxt;
            if (!last_bit) begin
               idx_q    <= idx_q + 5'd1;
               // 5-bit add wraps mod 32 across the oscillator index space
               ro_sel_q <= base_q + idx_q + 5'd1;
            end
         end
         // The result word lands together with the done pulse.
         if (state_d == S_DONE) begin
            response_q <= work_resp_nxt;
            tie_q      <= work_tie_nxt;
         end
      end
   end

   assign bus.ro_sel   = ro_sel_q;
   assign bus.ro_en    = ro_en_q;
   assign bus.cnt_clr  = cnt_clr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.response = response_q;
   assign bus.tie_mask = tie_q;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// ---------------------------------------------------------------------------
// tb_puf_response_ctrl
// Directed bench for puf_response_ctrl with WINDOW=4, SETTLE=2, NBITS=8
// (per-bit period 8, done 65 cycles after the accepting edge).
// ---------------------------------------------------------------------------
module tb_puf_response_ctrl;

   localparam int W  = 4;
   localparam int S  = 2;
   localparam int NB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   puf_response_ctrl_if #(.NBITS(NB)) ifc ();

   puf_response_ctrl #(
      .WINDOW_CYCLES (W),
      .SETTLE_CYCLES (S),
      .NBITS         (NB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---- counter model: per-bit counts from tables, bit index from cnt_clr ----
   logic [7:0] ca [NB];
   logic [7:0] cb [NB];
   logic [2:0] cur = 3'd0;
   logic [2:0] clr_seen = 3'd0;

   always @(posedge clk) begin
      if (ifc.start && !ifc.busy) begin
         clr_seen <= 3'd0;
      end else if (ifc.cnt_clr) begin
         cur      <= clr_seen;
         clr_seen <= clr_seen + 3'd1;
      end
   end

   assign ifc.count_a = ca[cur];
   assign ifc.count_b = cb[cur];

   // ---- monitor: record ro_sel per bit, enable window lengths, violations ----
   logic [4:0] sel_q [$];
   int         en_lens [$];
   int         en_len = 0;
   int         clr_viol = 0;
   int         en_viol = 0;
   int         sel_viol = 0;
   logic       prev_clr = 1'b0;
   logic       prev_en = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         en_len   = 0;
         prev_clr = 1'b0;
         prev_en  = 1'b0;
      end else begin
         if (ifc.cnt_clr) begin
            sel_q.push_back(ifc.ro_sel);
            if (prev_clr) clr_viol++;
         end
         if (ifc.ro_en) begin
            if (!prev_en && !prev_clr) en_viol++;
            if (ifc.cnt_clr) en_viol++;
            if (sel_q.size() == 0 || ifc.ro_sel != sel_q[$]) sel_viol++;
            en_len++;
         end else if (prev_en) begin
            en_lens.push_back(en_len);
            en_len = 0;
         end
         prev_clr = ifc.cnt_clr;
         prev_en  = ifc.ro_en;
      end
   end

   // ---- stimulus helpers ----
   task automatic set_alt();
      for (int i = 0; i < NB; i++) begin
         ca[i] = (i % 2 == 0) ? 8'd20 : 8'd10;
         cb[i] = (i % 2 == 0) ? 8'd10 : 8'd20;
      end
   endtask

   // bit0 tie, 1:200>100, 2:5<6, 3:255>0, 4:0<255, 5:129>128, 6:127<128, 7 tie
   // -> response 0x2A, tie_mask 0x81
   task automatic set_tie();
      ca[0] = 8'd33;  cb[0] = 8'd33;
      ca[1] = 8'd200; cb[1] = 8'd100;
      ca[2] = 8'd5;   cb[2] = 8'd6;
      ca[3] = 8'd255; cb[3] = 8'd0;
      ca[4] = 8'd0;   cb[4] = 8'd255;
      ca[5] = 8'd129; cb[5] = 8'd128;
      ca[6] = 8'd127; cb[6] = 8'd128;
      ca[7] = 8'd0;   cb[7] = 8'd0;
   endtask

   // Leaves the bench #1 into cycle 1 after the accepting edge.
   task automatic do_start(input logic [4:0] c);
      @(posedge clk); #1;
      ifc.start     = 1'b1;
      ifc.challenge = c;
      @(posedge clk); #1;
      ifc.start     = 1'b0;
   endtask

   // n = cycle number (edges after the accepting edge) in which done is seen.
   // With poke set, extra start pulses are injected while busy.
   task automatic wait_done(input bit poke, output int n);
      n = 1;
      while (!ifc.done && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (poke) ifc.start = (n % 20 == 10);
      end
      ifc.start = 1'b0;
      if (!ifc.done) begin
         chk("done_timeout", 32'd0, 32'd1);
         n = -1;
      end
   endtask

   int         n, n2, s0, e0, cv0, ev0, sv0, extra;
   logic [7:0] held_resp;
   logic       changed;
   logic [4:0] wrap_exp [8] = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};

   task automatic snap();
      s0  = sel_q.size();
      e0  = en_lens.size();
      cv0 = clr_viol;
      ev0 = en_viol;
      sv0 = sel_viol;
   endtask

   task automatic check_windows(input string tag);
      chk({tag, "_nclr"}, 32'(sel_q.size() - s0), 32'd8);
      chk({tag, "_nen"}, 32'(en_lens.size() - e0), 32'd8);
      for (int i = e0; i < en_lens.size(); i++) chk({tag, "_enlen"}, 32'(en_lens[i]), 32'd4);
      chk({tag, "_clr_viol"}, 32'(clr_viol - cv0), 32'd0);
      chk({tag, "_en_viol"}, 32'(en_viol - ev0), 32'd0);
      chk({tag, "_sel_hold"}, 32'(sel_viol - sv0), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.start     = 1'b0;
      ifc.challenge = 5'd0;
      set_alt();

      // ---- reset state ----
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ro_sel", 32'(ifc.ro_sel), 32'd0);
      chk("rst_ro_en", 32'(ifc.ro_en), 32'd0);
      chk("rst_cnt_clr", 32'(ifc.cnt_clr), 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_done", 32'(ifc.done), 32'd0);
      chk("rst_response", 32'(ifc.response), 32'd0);
      chk("rst_tie", 32'(ifc.tie_mask), 32'd0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);

      // ---- basic run: challenge 5, alternating counts ----
      set_alt();
      snap();
      do_start(5'd5);
      chk("basic_busy_c1", 32'(ifc.busy), 32'd1);
      chk("basic_clr_c1", 32'(ifc.cnt_clr), 32'd1);
      chk("basic_sel_c1", 32'(ifc.ro_sel), 32'd5);
      wait_done(1'b0, n);
      chk("basic_done_cycle", 32'(n), 32'd65);
      chk("basic_response", 32'(ifc.response), 32'h55);
      chk("basic_tie", 32'(ifc.tie_mask), 32'h00);
      chk("basic_busy_at_done", 32'(ifc.busy), 32'd1);
      @(posedge clk); #1;
      chk("basic_busy_fall", 32'(ifc.busy), 32'd0);
      chk("basic_done_pulse", 32'(ifc.done), 32'd0);
      for (int i = 0; i < 8; i++)
         if (s0 + i < sel_q.size()) chk("basic_sel_seq", 32'(sel_q[s0+i]), 32'(5 + i));
      check_windows("basic");

      // ---- wrap-around: challenge 30 ----
      snap();
      do_start(5'd30);
      wait_done(1'b0, n);
      chk("wrap_done_cycle", 32'(n), 32'd65);
      for (int i = 0; i < 8; i++)
         if (s0 + i < sel_q.size()) chk("wrap_sel_seq", 32'(sel_q[s0+i]), 32'(wrap_exp[i]));
      check_windows("wrap");

      // ---- ties ----
      set_tie();
      do_start(5'd0);
      wait_done(1'b0, n);
      chk("tie_response", 32'(ifc.response), 32'h2A);
      chk("tie_mask", 32'(ifc.tie_mask), 32'h81);

      // ---- extra start pulses during a run ----
      set_alt();
      do_start(5'd3);
      wait_done(1'b1, n);
      chk("extra_done_cycle", 32'(n), 32'd65);
      chk("extra_response", 32'(ifc.response), 32'h55);
      extra = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (ifc.done || ifc.busy) extra++;
      end
      chk("extra_no_second_run", 32'(extra), 32'd0);

      // ---- start held high: back-to-back runs ----
      set_alt();
      @(posedge clk); #1;
      ifc.start     = 1'b1;
      ifc.challenge = 5'd5;
      @(posedge clk); #1;
      n = 1;
      while (!ifc.done && n < 200) begin @(posedge clk); #1; n++; end
      chk("held_first_done", 32'(n), 32'd65);
      chk("held_first_resp", 32'(ifc.response), 32'h55);
      held_resp = ifc.response;
      set_tie();
      changed = 1'b0;
      n2 = 0;
      @(posedge clk); #1;
      n2 = 1;
      while (!ifc.done && n2 < 200) begin
         if (ifc.response != held_resp) changed = 1'b1;
         @(posedge clk); #1;
         n2++;
      end
      ifc.start = 1'b0;
      chk("held_period", 32'(n2), 32'd66);
      chk("held_resp_stable", 32'(changed), 32'd0);
      chk("held_second_resp", 32'(ifc.response), 32'h2A);
      chk("held_second_tie", 32'(ifc.tie_mask), 32'h81);
      repeat (3) @(posedge clk);
      #1;
      chk("held_released_idle", 32'(ifc.busy), 32'd0);

      // ---- asynchronous reset mid-RUN ----
      set_alt();
      do_start(5'd9);
      repeat (19) @(posedge clk);
      #1;
      chk("mid_in_run", 32'(ifc.ro_en), 32'd1);
      #1 rst_n = 1'b1;
      #1;
      chk("mid_rst_ro_en", 32'(ifc.ro_en), 32'd0);
      chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
      chk("mid_rst_ro_sel", 32'(ifc.ro_sel), 32'd0);
      chk("mid_rst_response", 32'(ifc.response), 32'd0);
      chk("mid_rst_tie", 32'(ifc.tie_mask), 32'd0);
      chk("mid_rst_clr_done", 32'({ifc.cnt_clr, ifc.done}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      extra = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (ifc.busy || ifc.done) extra++;
      end
      chk("post_rst_idle", 32'(extra), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/puf_response_ctrl.md
# puf_response_ctrl

Sequencing controller that sits directly downstream of the two ring-oscillator PUF banks and their edge counters. Per response bit it drives the 5-bit oscillator select, clears both counters, enables the oscillators for a fixed window, and lets the counts settle. It then compares the two frozen 8-bit counts and shifts one bit into an NBITS-bit response register. A single `start` pulse runs NBITS consecutive challenges and yields one registered response word, a tie mask and a `done` pulse.

## Interface
- `WINDOW_CYCLES`, 64: clk cycles the oscillators are enabled per bit; legal range 1..65535.
- `SETTLE_CYCLES`, 4: clk cycles after enable drops before counts are sampled; legal range 1..255.
- `NBITS`, 8: response bits per run; legal range 1..32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset rst_n, asynchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `challenge`  in  5  base oscillator index; captured on an accepted `start`.
- `count_a`  in  8  bank-A counter value; read only in COMPARE.
- `count_b`  in  8  bank-B counter value; read only in COMPARE.
- `ro_sel`  out  5  oscillator select driven to both bank muxes.
- `ro_en`  out  1  oscillator enable; high only in RUN.
- `cnt_clr`  out  1  active-high counter clear; high only in CLEAR.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `response` and `tie_mask` update.
- `response`  out  NBITS  last completed response word; bit i belongs to challenge i.
- `tie_mask`  out  NBITS  bit i set when `count_a` == `count_b` for bit i.

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
- IDLE: when `start`=1, capture `challenge` into `base`, set `idx`=0, clear the shift registers, go to CLEAR. When `start`=0, remain in IDLE.
- `ro_sel` = (`base` + `idx`) mod 32. It uses 5-bit wrap-around, for example base 30 with idx 3 gives 1. `ro_sel` holds its value from CLEAR through COMPARE.
- CLEAR: lasts 1 cycle with `cnt_clr`=1. Go to RUN.
- RUN: `ro_en`=1 for exactly WINDOW_CYCLES cycles, tracked by a 16-bit down-counter. Go to SETTLE.
- SETTLE: `ro_en`=0 for SETTLE_CYCLES cycles. This absorbs the mux and counter ripple. Go to COMPARE.
- COMPARE: lasts 1 cycle.
  - The response bit is 1 when `count_a` > `count_b` (unsigned), otherwise 0.
  - The tie bit is 1 when the counts are equal.
  - Both bits are written at position `idx`.
  - If `idx` = NBITS-1, go to DONE. Otherwise increment `idx` and go to CLEAR.
- DONE: lasts 1 cycle.
  - Copy the working registers to `response` and `tie_mask`.
  - `done`=1.
  - Return to IDLE.
- `start` is ignored while `busy`=1. It is never queued.
- `response` and `tie_mask` hold their values between runs. They change only in DONE or on reset.
- Counter overflow is not detected. Counts wrap mod 256, and WINDOW_CYCLES is chosen by integration so that counts stay below 256.

## Timing
- Reset values while `rst_n`=1:
  - State: IDLE.
  - `ro_sel`=0, `ro_en`=0, `cnt_clr`=0, `busy`=0, `done`=0.
  - `response`=0, `tie_mask`=0.
  - All internal counters: 0.
- Reset asserted mid-run: the run is aborted immediately and asynchronously. Outputs take their reset values, and no `done` is produced.
- All outputs are registered, so none has a combinational path from inputs.
- Timing from a `start` accepted at edge 0:
  - `busy`=1 and `cnt_clr`=1 in cycle 1.
  - Per-bit period P = WINDOW_CYCLES + SETTLE_CYCLES + 2.
  - `done` is high in cycle NBITS·P + 1.
  - `busy` falls the cycle after `done`.
- Earliest restart: `start` in the cycle after `done` is accepted.
- `start` held high continuously produces back-to-back runs separated by one IDLE cycle.
- `count_a` and `count_b` must be stable throughout COMPARE.

## Test plan
- Reset and idle: assert `rst_n`=1 mid-RUN.
  - All outputs go to 0 asynchronously.
  - After release with `start`=0, `busy` stays 0 for 100 cycles.
- Basic run: WINDOW=4, SETTLE=2, NBITS=8, challenge=5. The model drives `count_a`=20 and `count_b`=10 on even bits, and the reverse on odd bits.
  - `response`=0x55, `tie_mask`=0x00.
  - `done` in cycle 65.
  - `ro_sel` steps 5 through 12.
- Wrap-around: challenge=30.
  - `ro_sel` sequence is 30, 31, 0, 1, 2, 3, 4, 5.
- Ties: equal counts on bits 0 and 7.
  - `tie_mask`=0x81, and `response` bits 0 and 7 are 0.
- Enable windowing: on every bit, `cnt_clr` is high for exactly 1 cycle, then `ro_en` is high for exactly 4 consecutive cycles. `ro_en` is never high in CLEAR, SETTLE or COMPARE.
- Start handling:
  - Extra `start` pulses during a run have no effect, and exactly one `done` is produced.
  - `start` held high gives `done` pulses 66 cycles apart.
  - `response` is unchanged between `done` pulses.
